// File: rtl/step_dir_decoder.sv
// Step/dir receiver: synchronizes step_in/dir_in, decodes accepted pulses into a
// wrapping 24-bit position and measures the step period. Macro STEP_DIR_DECODER_FILTER_EN enables the pulse-width filter.
module step_dir_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_PULSE   = 1,
  parameter int unsigned TIMEOUT     = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_in,
  input  logic        dir_in,
  input  logic        clear,
  output logic [23:0] position,
  output logic [31:0] feedback_position,
  output logic        dir_out,
  output logic        step_strobe,
  output logic [27:0] step_period,
  output logic        moving,
  output logic        pulse_error
);

  // Out-of-range parameters elaborate an empty marker scope named for the offence.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
  end
  if (MIN_PULSE < 1 || MIN_PULSE > 255) begin : g_bad_min_pulse
  end
  if (TIMEOUT == 0 || TIMEOUT >= 32'd268435456) begin : g_bad_timeout
  end

  localparam logic [27:0] TIMEOUT_W = 28'(TIMEOUT);

  logic [SYNC_STAGES-1:0] step_sync;
  logic [SYNC_STAGES-1:0] dir_sync;
  logic                   s_step;
  logic                   s_dir;
  logic                   dir_hold;
  logic                   accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_sync <= '0;
      dir_sync  <= '0;
    end else begin
      step_sync <= {step_sync[SYNC_STAGES-2:0], step_in};
      dir_sync  <= {dir_sync[SYNC_STAGES-2:0], dir_in};
    end
  end

  assign s_step = step_sync[SYNC_STAGES-1];
  assign s_dir  = dir_sync[SYNC_STAGES-1];

  // Direction is captured only while step is low, so a dir flip on the step edge is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_hold <= 1'b0;
    end else if (!s_step) begin
      dir_hold <= s_dir;
    end
  end

`ifdef STEP_DIR_DECODER_FILTER_EN
  localparam logic [7:0] MIN_PULSE_W = 8'(MIN_PULSE);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    WAIT_LOW
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] hcnt;
  logic [7:0] hcnt_next;
  logic       pulse_error_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hcnt        <= '0;
      pulse_error <= 1'b0;
    end else begin
      state       <= state_next;
      hcnt        <= hcnt_next;
      pulse_error <= pulse_error_next;
    end
  end

  always_comb begin
    state_next       = state;
    hcnt_next        = hcnt;
    pulse_error_next = pulse_error;
    accept           = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_step) begin
          hcnt_next = 8'd1;
          if (MIN_PULSE_W == 8'd1) begin
            accept     = 1'b1;
            state_next = WAIT_LOW;
          end else begin
            state_next = HIGH;
          end
        end
      end
      HIGH: begin
        if (s_step) begin
          hcnt_next = hcnt + 8'd1;
          if (hcnt + 8'd1 == MIN_PULSE_W) begin
            accept     = 1'b1;
            state_next = WAIT_LOW;
          end
        end else begin
          pulse_error_next = 1'b1;
          state_next       = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!s_step) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
`else
  typedef enum logic {
    IDLE,
    WAIT_LOW
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (s_step) begin
          accept     = 1'b1;
          state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!s_step) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pulse_error = 1'b0;
`endif

  // Clear outranks a same-cycle accept for position only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position    <= '0;
      dir_out     <= 1'b0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= accept;
      if (accept) begin
        dir_out <= dir_hold;
      end
      if (clear) begin
        position <= '0;
      end else if (accept) begin
        position <= dir_hold ? position - 24'd1 : position + 24'd1;
      end
    end
  end

  assign feedback_position = {8'b0, position};

  logic [27:0] pcnt;
  logic [27:0] pcnt_inc;

  assign pcnt_inc = (pcnt == TIMEOUT_W) ? pcnt : pcnt + 28'd1;

  // The period is pcnt+1 because pcnt restarts from 0 on the accept edge itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt        <= '0;
      moving      <= 1'b0;
      step_period <= '0;
    end else if (accept) begin
      step_period <= moving ? pcnt + 28'd1 : '0;
      pcnt        <= '0;
      moving      <= 1'b1;
    end else begin
      pcnt <= pcnt_inc;
      if (pcnt_inc == TIMEOUT_W) begin
        moving      <= 1'b0;
        step_period <= '0;
      end
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Self-checking bench for step_dir_decoder: directed scenarios plus randomized
// traffic compared against a sample-history reference model.
module tb_step_dir_decoder;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MIN_PULSE   = 4;
  localparam int unsigned TIMEOUT     = 1000;
`ifdef STEP_DIR_DECODER_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  localparam int unsigned MEFF = FILTER ? MIN_PULSE : 1;
  localparam int unsigned PW   = MEFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_in;
  logic        dir_in;
  logic        clear;
  logic [23:0] position;
  logic [31:0] feedback_position;
  logic        dir_out;
  logic        step_strobe;
  logic [27:0] step_period;
  logic        moving;
  logic        pulse_error;

  int total        = 0;
  int bad          = 0;
  int strobes_seen = 0;

  step_dir_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_PULSE  (MIN_PULSE),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .step_in          (step_in),
    .dir_in           (dir_in),
    .clear            (clear),
    .position         (position),
    .feedback_position(feedback_position),
    .dir_out          (dir_out),
    .step_strobe      (step_strobe),
    .step_period      (step_period),
    .moving           (moving),
    .pulse_error      (pulse_error)
  );

  always #5 clk = ~clk;

  // Reference model: input history delayed by the synchronizer depth, run-length pulse rules.
  bit          sq[SYNC_STAGES];
  bit          dq[SYNC_STAGES];
  int unsigned run_len;
  bit          last_low_dir;
  logic [23:0] m_pos;
  bit          m_dir;
  bit          m_strobe;
  bit          m_moving;
  bit          m_err;
  logic [27:0] m_period;
  longint      cyc;
  longint      last_acc;

  function automatic void model_reset();
    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
      sq[i] = 1'b0;
      dq[i] = 1'b0;
    end
    run_len      = 0;
    last_low_dir = 1'b0;
    m_pos        = '0;
    m_dir        = 1'b0;
    m_strobe     = 1'b0;
    m_moving     = 1'b0;
    m_err        = 1'b0;
    m_period     = '0;
    last_acc     = cyc;
  endfunction

  function automatic void model_step(input bit st, input bit dr, input bit cl);
    bit sv;
    bit sd;
    bit acc;
    bit acc_dir;
    sv = sq[SYNC_STAGES-1];
    sd = dq[SYNC_STAGES-1];
    for (int i = int'(SYNC_STAGES) - 1; i > 0; i--) begin
      sq[i] = sq[i-1];
      dq[i] = dq[i-1];
    end
    sq[0]   = st;
    dq[0]   = dr;
    cyc     = cyc + 1;
    acc     = 1'b0;
    acc_dir = last_low_dir;
    if (sv) begin
      if (run_len < 1000) run_len++;
      if (run_len == MEFF) acc = 1'b1;
    end else begin
      if (run_len > 0 && run_len < MEFF) m_err = 1'b1;
      run_len      = 0;
      last_low_dir = sd;
    end
    m_strobe = acc;
    if (acc) begin
      m_dir    = acc_dir;
      m_period = m_moving ? 28'(cyc - last_acc) : 28'd0;
      m_moving = 1'b1;
      last_acc = cyc;
    end else if (m_moving && (cyc - last_acc) == longint'(TIMEOUT)) begin
      m_moving = 1'b0;
      m_period = '0;
    end
    if (cl) m_pos = '0;
    else if (acc) m_pos = acc_dir ? m_pos - 24'd1 : m_pos + 24'd1;
  endfunction

  task automatic tick(input bit st, input bit dr, input bit cl);
    @(negedge clk);
    step_in = st;
    dir_in  = dr;
    clear   = cl;
    @(posedge clk);
    if (!reset) model_step(st, dr, cl);
    #1;
    if (step_strobe) strobes_seen++;
  endtask

  task automatic release_reset(input bit st);
    @(negedge clk);
    reset   = 1'b0;
    step_in = st;
    dir_in  = 1'b0;
    clear   = 1'b0;
    @(posedge clk);
    model_step(st, 1'b0, 1'b0);
    #1;
    if (step_strobe) strobes_seen++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset   = 1'b1;
    step_in = 1'b0;
    dir_in  = 1'b0;
    clear   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({position, feedback_position, dir_out, step_strobe, step_period, moving, pulse_error} !== 88'd0) begin
      bad++;
      $display("FAIL reset_values got pos=%h fb=%h dir=%b stb=%b per=%0d mov=%b err=%b exp all zero",
               position, feedback_position, dir_out, step_strobe, step_period, moving, pulse_error);
    end
    release_reset(1'b0);
  endtask

  task automatic test_count_up();
    int          s0;
    int unsigned exp_per;
    s0 = strobes_seen;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 100; c++) tick(c < int'(PW), 1'b0, 1'b0);
      exp_per = (k == 0) ? 0 : 100;
      total++;
      if (step_period !== 28'(exp_per)) begin
        bad++;
        $display("FAIL up_period step%0d got=%0d exp=%0d", k + 1, step_period, exp_per);
      end
    end
    total++;
    if (position !== 24'd5) begin
      bad++;
      $display("FAIL up_position got=%h exp=000005", position);
    end
    total++;
    if (strobes_seen - s0 != 5) begin
      bad++;
      $display("FAIL up_strobes got=%0d exp=5", strobes_seen - s0);
    end
    total++;
    if (moving !== 1'b1 || dir_out !== 1'b0) begin
      bad++;
      $display("FAIL up_moving_dir got mov=%b dir=%b exp mov=1 dir=0", moving, dir_out);
    end
  endtask

  task automatic test_count_down();
    tick(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 20; c++) tick(c < int'(PW), 1'b1, 1'b0);
    end
    total++;
    if (position !== 24'hFFFFFD) begin
      bad++;
      $display("FAIL down_position got=%h exp=fffffd", position);
    end
    total++;
    if (dir_out !== 1'b1) begin
      bad++;
      $display("FAIL down_dir got=%b exp=1", dir_out);
    end
    total++;
    if (feedback_position !== 32'h00FFFFFD) begin
      bad++;
      $display("FAIL down_feedback got=%h exp=00fffffd", feedback_position);
    end
  endtask

  task automatic test_dir_same_edge();
    int s0;
    s0 = strobes_seen;
    repeat (6) tick(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) tick(c < int'(PW), 1'b1, 1'b0);
    total++;
    if (position !== 24'hFFFFFE || dir_out !== 1'b0 || strobes_seen - s0 != 1) begin
      bad++;
      $display("FAIL same_edge_dir got pos=%h dir=%b strobes=%0d exp pos=fffffe dir=0 strobes=1",
               position, dir_out, strobes_seen - s0);
    end
  endtask

  task automatic test_min_pulse();
    tick(1'b0, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 22; c++) tick(c < 2, 1'b0, 1'b0);
    total++;
    if (pulse_error !== FILTER) begin
      bad++;
      $display("FAIL short_pulse_error got=%b exp=%b", pulse_error, FILTER);
    end
    for (int c = 0; c < 24; c++) tick(c < int'(MIN_PULSE), 1'b0, 1'b0);
    total++;
    if (position !== (FILTER ? 24'd1 : 24'd2)) begin
      bad++;
      $display("FAIL min_pulse_position got=%h exp=%h", position, FILTER ? 24'd1 : 24'd2);
    end
    total++;
    if (pulse_error !== FILTER) begin
      bad++;
      $display("FAIL min_pulse_error got=%b exp=%b", pulse_error, FILTER);
    end
  endtask

  task automatic test_timeout();
    bit found;
    repeat (TIMEOUT + 100) tick(1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(i < int'(PW), 1'b0, 1'b0);
      if (step_strobe) found = 1'b1;
    end
    total++;
    if (!found || step_period !== 28'd0) begin
      bad++;
      $display("FAIL timeout_first_step got found=%b per=%0d exp found=1 per=0", found, step_period);
    end
    repeat (TIMEOUT - 1) tick(1'b0, 1'b0, 1'b0);
    total++;
    if (moving !== 1'b1) begin
      bad++;
      $display("FAIL timeout_before got mov=%b exp=1", moving);
    end
    tick(1'b0, 1'b0, 1'b0);
    total++;
    if (moving !== 1'b0 || step_period !== 28'd0) begin
      bad++;
      $display("FAIL timeout_at got mov=%b per=%0d exp mov=0 per=0", moving, step_period);
    end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(i < int'(PW), 1'b0, 1'b0);
      if (step_strobe) found = 1'b1;
    end
    total++;
    if (!found || step_period !== 28'd0 || moving !== 1'b1) begin
      bad++;
      $display("FAIL timeout_restart got found=%b per=%0d mov=%b exp found=1 per=0 mov=1",
               found, step_period, moving);
    end
  endtask

  task automatic test_clear_accept();
    for (int c = 0; c < 10; c++) tick(c < int'(PW), 1'b0, 1'b0);
    for (int c = 0; c < int'(SYNC_STAGES + MEFF); c++) begin
      tick(c < int'(PW), 1'b0, c == int'(SYNC_STAGES + MEFF - 1));
    end
    total++;
    if (position !== 24'd0 || step_strobe !== 1'b1) begin
      bad++;
      $display("FAIL clear_on_accept got pos=%h stb=%b exp pos=000000 stb=1", position, step_strobe);
    end
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    total++;
    if (position !== 24'd0) begin
      bad++;
      $display("FAIL clear_step_dropped got pos=%h exp=000000", position);
    end
  endtask

  task automatic test_reset_mid_pulse();
    for (int c = 0; c < 10; c++) tick(c < int'(PW), 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if ({position, feedback_position, dir_out, step_strobe, step_period, moving, pulse_error} !== 88'd0) begin
      bad++;
      $display("FAIL reset_mid_pulse got pos=%h dir=%b stb=%b per=%0d mov=%b err=%b exp all zero",
               position, dir_out, step_strobe, step_period, moving, pulse_error);
    end
    @(negedge clk);
    release_reset(1'b1);
    for (int c = 1; c < 12; c++) tick(c < int'(PW), 1'b0, 1'b0);
    total++;
    if (position !== 24'd1 || pulse_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_then_high got pos=%h err=%b exp pos=000001 err=0", position, pulse_error);
    end
  endtask

  task automatic test_random();
    bit          d;
    bit          cl;
    bit          dd;
    int unsigned w;
    int unsigned g;
    for (int n = 0; n < 80; n++) begin
      d = 1'($urandom_range(1));
      w = $urandom_range(6, 1);
      g = ($urandom_range(14) == 0) ? $urandom_range(1100, 990) : $urandom_range(6, 1);
      for (int c = 0; c < int'(w + g); c++) begin
        cl = ($urandom_range(24) == 0);
        dd = ($urandom_range(7) == 0) ? ~d : d;
        tick(c < int'(w), dd, cl);
        total++;
        if ({position, feedback_position, dir_out, step_strobe, step_period, moving, pulse_error} !==
            {m_pos, 8'h00, m_pos, m_dir, m_strobe, m_period, m_moving, m_err}) begin
          bad++;
          $display("FAIL random cyc=%0d got pos=%h fb=%h dir=%b stb=%b per=%0d mov=%b err=%b exp pos=%h dir=%b stb=%b per=%0d mov=%b err=%b",
                   cyc, position, feedback_position, dir_out, step_strobe, step_period, moving, pulse_error,
                   m_pos, m_dir, m_strobe, m_period, m_moving, m_err);
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    step_in = 1'b0;
    dir_in  = 1'b0;
    clear   = 1'b0;
    cyc     = 0;
    model_reset();
    test_reset();
    test_count_up();
    test_count_down();
    test_dir_same_edge();
    test_min_pulse();
    test_timeout();
    test_clear_accept();
    test_reset_mid_pulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=time limit exp=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/step_dir_decoder.md
# step_dir_decoder

Receive-side decoder for a step/dir motor interface. It synchronizes external `step_in`/`dir_in` lines and rejects step pulses that are too short. Each accepted pulse moves a 24-bit position counter up or down, and the block measures the interval between steps. Uses: loopback verification of the stepper generators, and following an external step/dir master on the DE0 board.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on `step_in` and `dir_in`; legal range 2..4.
- `MIN_PULSE`, 1: minimum synchronized high time, in clocks, for a step to be accepted; legal range 1..255.
- `TIMEOUT`, 2_000_000: clocks without an accepted step before the block declares it is stopped; must be below 2^28.

Ports (`name  direction  width  meaning`):
- `clk  in  1  system clock`
- `reset  in  1  asynchronous, active-high reset`
- `step_in  in  1  asynchronous step line; a rising edge starts a pulse`
- `dir_in  in  1  asynchronous direction line; 0 = increment, 1 = decrement`
- `clear  in  1  synchronous clear of position`
- `position  out  24  decoded position, wraps modulo 2^24`
- `feedback_position  out  32  {8'b0, position}`
- `dir_out  out  1  direction of the last accepted step`
- `step_strobe  out  1  high for 1 cycle when a step is accepted`
- `step_period  out  28  clocks between the last two accepted steps; 0 = unknown or stopped`
- `moving  out  1  an accepted step occurred less than TIMEOUT clocks ago`
- `pulse_error  out  1  sticky flag: a step pulse was rejected as too short`

## Operation
- Synchronizers: `s_step` and `s_dir` are the last stages of the `SYNC_STAGES`-deep chains.
- `dir_hold` register: loads `s_dir` on every cycle in which `s_step` is 0. The accepted direction is always `dir_hold`, i.e. the value while step was low. This keeps the decode correct when the driver flips dir on the same edge that step rises.
- Pulse FSM (`hcnt` is 8 bits):
  - IDLE: when `s_step`=1, set `hcnt`=1. If `MIN_PULSE`=1, accept immediately and go to WAIT_LOW; otherwise go to HIGH.
  - HIGH, `s_step`=1: `hcnt`++. When `hcnt` reaches `MIN_PULSE`, accept and go to WAIT_LOW.
  - HIGH, `s_step`=0: set `pulse_error`=1, discard the pulse, go to IDLE.
  - WAIT_LOW: when `s_step`=0, go to IDLE.
- Accept action:
  - `step_strobe`=1 for one cycle.
  - `position` moves ±1 according to `dir_hold`; 0xFFFFFF+1 wraps to 0, and 0−1 wraps to 0xFFFFFF.
  - `dir_out` ← `dir_hold`.
- Period counter `pcnt` (28 bits):
  - Increments every cycle and saturates at `TIMEOUT`.
  - On accept:
    - If `moving`=1, `step_period` ← `pcnt`+1.
    - If `moving`=0, `step_period` stays 0.
    - Then `pcnt` ← 0 and `moving` ← 1.
  - When `pcnt` reaches `TIMEOUT`, set `moving` ← 0 and `step_period` ← 0.
- `clear`:
  - Forces `position` to 0 and has priority over a simultaneous accept; that step is not counted.
  - The same step still updates `step_strobe`, `dir_out`, `step_period` and `moving`.
  - `clear` does not clear `pulse_error`. Only `reset` clears `pulse_error`.

## Timing
- Reset values: `position`=0, `feedback_position`=0, `dir_out`=0, `step_strobe`=0, `step_period`=0, `moving`=0, `pulse_error`=0. Synchronizers, `dir_hold`, `hcnt` and `pcnt` reset to 0; FSM resets to IDLE.
- Latency: if `step_in` is first sampled high at edge 0, `position` changes at edge `SYNC_STAGES`+`MIN_PULSE`−1. That is edge 2 with default parameters. `step_strobe` is high during the cycle after that edge.
- `dir_out` and `step_period` update on the same edge as `position`.
- Minimum step spacing is `MIN_PULSE`+1 synchronized cycles (high then low). A pulse that is 1-cycle high and 1-cycle low is decoded at every step with `MIN_PULSE`=1.
- `reset` asserted mid-pulse: the pulse is lost. After release, a `step_in` that is still high is treated as a new rising edge.

## Configuration
- `STEP_DIR_DECODER_FILTER_EN` defined:
  - Pulse-width filter active as described in Operation.
- Not defined:
  - HIGH state removed; `MIN_PULSE` is ignored.
  - A step is accepted on the IDLE→WAIT_LOW transition, i.e. on any synchronized rising edge.
  - `pulse_error` is tied to 0.

## Test plan
- Reset, then 5 pulses of 1-cycle width with `dir_in`=0 every 100 clocks -> `position`=5, 5 `step_strobe`s; `step_period`=0 after the 1st step, 100 after the 2nd–5th; `moving`=1.
- `position`=0, 3 pulses with `dir_in`=1 -> `position`=0xFFFFFD, `dir_out`=1, `feedback_position`=0x00FFFFFD.
- `dir_in` toggles 0→1 on the same edge `step_in` rises -> step counted as increment, `dir_out`=0.
- `MIN_PULSE`=4, inject a 2-cycle pulse then a 4-cycle pulse -> first rejected with `pulse_error`=1; second counted, `position`=1. With the macro undefined -> `position`=2 and `pulse_error`=0.
- `TIMEOUT`=1000, one step then idle -> `moving` falls at 1000 clocks after the accept and `step_period`=0; the next step leaves `step_period` at 0.
- Assert `clear` on the accept cycle -> `position`=0, `step_strobe`=1; `reset` mid-pulse -> all outputs at reset values within 1 clock.
